swan_vartheta_seq: RTL and testbench



---
 rtl/swan_pkg.sv | 52 +++++
 rtl/swan_col_rot.sv | 19 +
 rtl/swan_vartheta_seq.sv | 114 +++++++++++
 tb/tb_swan_vartheta_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/swan_pkg.sv
// Shared types and constants for the SWAN multi-cycle vartheta column rotation.
// Holds the FSM states, the default rotation amounts and the step-count helpers.
package swan_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } swanState_e;

   function automatic int colSize(input int sideSize);
      return sideSize / 4;
   endfunction

   function automatic int defaultPa(input int blockSize);
      return 1;
   endfunction

   function automatic int defaultPb(input int blockSize);
      case (blockSize)
         64:      return 3;
         128:     return 5;
         default: return 9;
      endcase
   endfunction

   function automatic int defaultPc(input int blockSize);
      case (blockSize)
         64:      return 5;
         128:     return 11;
         default: return 19;
      endcase
   endfunction

   // Number of shift cycles: the largest rotation split into STEP-sized pieces.
   function automatic int calcNs(input int pa, input int pb, input int pc, input int step);
      int m;
      m = pa;
      if (pb > m) m = pb;
      if (pc > m) m = pc;
      return (m + step - 1) / step;
   endfunction

   function automatic int subStep(input int p, input int k, input int step);
      int rem;
      rem = p - k * step;
      if (rem < 0) rem = 0;
      if (rem > step) rem = step;
      return rem;
   endfunction

endpackage

// File: rtl/swan_col_rot.sv
// Combinational rotator for one column; amount 0..STEP.
// dir_i=0 moves bits toward higher index, dir_i=1 toward lower index.
module swan_col_rot #(
   parameter int W     = 32,
   parameter int AMT_W = 3
) (
   input  logic [0:W-1]       data_i,
   input  logic [AMT_W-1:0]   amt_i,
   input  logic               dir_i,
   output logic [0:W-1]       data_o
);

   logic [2*W-1:0] dbl;

   // Index 0 is the numeric MSB, so toward-higher-index is a numeric right rotate.
   assign dbl    = {data_i, data_i};
   assign data_o = dir_i ? W'((dbl << amt_i) >> W) : W'(dbl >> amt_i);

endmodule

// File: rtl/swan_vartheta_seq.sv
// Multi-cycle SWAN vartheta: rotates three columns of a half-state STEP bits per clock.
// Define SWAN_VARTHETA_INV_EN to honour the inv port (inverse rotation for decryption).
module swan_vartheta_seq
   import swan_pkg::*;
#(
   parameter int BLOCK_SIZE  = 256,
   parameter int SIDE_SIZE   = BLOCK_SIZE / 2,
   parameter int COLUMN_SIZE = colSize(SIDE_SIZE),
   parameter int PA          = defaultPa(BLOCK_SIZE),
   parameter int PB          = defaultPb(BLOCK_SIZE),
   parameter int PC          = defaultPc(BLOCK_SIZE),
   parameter int STEP        = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 inv,
   input  logic [0:SIDE_SIZE-1] x,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [0:SIDE_SIZE-1] y
);

   localparam int NS    = calcNs(PA, PB, PC, STEP);
   localparam int AMT_W = $clog2(STEP + 1);
   localparam int CNT_W = $clog2(COLUMN_SIZE + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = (NS == 0) ? '0 : CNT_W'(NS - 1);

   swanState_e             stateQ, stateD;
   logic [0:SIDE_SIZE-1]   dataQ, dataD, rotData;
   logic [CNT_W-1:0]       cntQ, cntD;
   logic                   dirBit;

`ifdef SWAN_VARTHETA_INV_EN
   logic invQ, invD;
   assign dirBit = invQ;
`else
   logic unusedInv;
   assign unusedInv = inv;
   assign dirBit    = 1'b0;
`endif

   // Column 0 takes PC, column 1 PB, column 2 PA; column 3 is never rotated.
   for (genvar c = 0; c < 3; c++) begin : g_col
      localparam int P = (c == 0) ? PC : (c == 1) ? PB : PA;
      logic [AMT_W-1:0] amt;
      assign amt = AMT_W'(subStep(P, int'(cntQ), STEP));
      swan_col_rot #(
         .W     (COLUMN_SIZE),
         .AMT_W (AMT_W)
      ) u_rot (
         .data_i (dataQ[c*COLUMN_SIZE +: COLUMN_SIZE]),
         .amt_i  (amt),
         .dir_i  (dirBit),
         .data_o (rotData[c*COLUMN_SIZE +: COLUMN_SIZE])
      );
   end
   assign rotData[3*COLUMN_SIZE +: COLUMN_SIZE] = dataQ[3*COLUMN_SIZE +: COLUMN_SIZE];

   always_comb begin
      stateD    = stateQ;
      dataD     = dataQ;
      cntD      = cntQ;
      in_ready  = (stateQ == IDLE);
      out_valid = (stateQ == DONE);
`ifdef SWAN_VARTHETA_INV_EN
      invD      = invQ;
`endif
      case (stateQ)
         IDLE: begin
            if (in_valid) begin
               dataD  = x;
               cntD   = '0;
`ifdef SWAN_VARTHETA_INV_EN
               invD   = inv;
`endif
               stateD = (NS == 0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            dataD = rotData;
            cntD  = cntQ + 1'b1;
            if (cntQ == LAST_CNT) stateD = DONE;
         end
         DONE: begin
            if (out_ready) stateD = IDLE;
         end
         default: stateD = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ <= IDLE;
         dataQ  <= '0;
         cntQ   <= '0;
      end else begin
         stateQ <= stateD;
         dataQ  <= dataD;
         cntQ   <= cntD;
      end
   end

`ifdef SWAN_VARTHETA_INV_EN
   always_ff @(posedge clk) begin
      if (rst) invQ <= 1'b0;
      else     invQ <= invD;
   end
`endif

   assign y = dataQ;

endmodule

// File: tb/tb_swan_vartheta_seq.sv
// Self-checking bench for swan_vartheta_seq at default parameters (BLOCK_SIZE=256, STEP=4).
// Follows SWAN_VARTHETA_INV_EN to decide whether inv must take effect.
module tb_swan_vartheta_seq;

   localparam int SIDE = 128;
   localparam int COL  = 32;
   localparam int NS   = (19 + 4 - 1) / 4;
`ifdef SWAN_VARTHETA_INV_EN
   localparam bit INV_ON = 1'b1;
`else
   localparam bit INV_ON = 1'b0;
`endif

   localparam logic [0:SIDE-1] X1 = 128'h00000001_80000000_00000001_DEADBEEF;
   localparam logic [0:SIDE-1] Y1 = 128'h00002000_00400000_80000000_DEADBEEF;

   logic            clk = 1'b0;
   logic            rst, inVal, inRdy, invIn, outVal, outRdy;
   logic [0:SIDE-1] xIn, yOut;

   int total = 0;
   int bad   = 0;

   bit              mReady = 1'b1;
   bit              mValid = 1'b0;
   int              mLeft  = 0;
   logic [0:SIDE-1] mExp   = '0;

   always #5 clk = ~clk;

   swan_vartheta_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inVal),
      .in_ready  (inRdy),
      .inv       (invIn),
      .x         (xIn),
      .out_valid (outVal),
      .out_ready (outRdy),
      .y         (yOut)
   );

   // Whole-column rotation by the full amount, done bit by bit on indices.
   function automatic logic [0:SIDE-1] refRot(input logic [0:SIDE-1] v, input bit backward);
      int amt[4] = '{19, 9, 1, 0};
      logic [0:SIDE-1] r;
      int dst;
      r = v;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < COL; i++) begin
            dst = backward ? (i - amt[c] + COL) % COL : (i + amt[c]) % COL;
            r[c*COL + dst] = v[c*COL + i];
         end
      end
      return r;
   endfunction

   function automatic logic [0:SIDE-1] randVec();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic checkOutput(input string name, input logic [SIDE-1:0] act,
                              input logic [SIDE-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [0:SIDE-1] v, input bit iv);
      int n = 0;
      while (!inRdy && n < 100) begin
         tick();
         n++;
      end
      if (!inRdy) checkOutput("accept_timeout", inRdy, 1);
      xIn   = v;
      invIn = iv;
      inVal = 1'b1;
      tick();
      inVal = 1'b0;
   endtask

   task automatic waitValid(output int cyc);
      cyc = 1;
      while (!outVal && cyc < 100) begin
         tick();
         cyc++;
      end
      if (!outVal) checkOutput("valid_timeout", outVal, 1);
   endtask

   // Transaction-level timing model: accept in idle, result after NS more edges.
   always @(posedge clk) begin
      if (rst) begin
         mReady = 1'b1;
         mValid = 1'b0;
         mLeft  = 0;
      end else if (mReady) begin
         if (inVal) begin
            mReady = 1'b0;
            mExp   = refRot(xIn, INV_ON && invIn);
            if (NS == 0) mValid = 1'b1;
            else         mLeft  = NS;
         end
      end else if (!mValid) begin
         mLeft--;
         if (mLeft == 0) mValid = 1'b1;
      end else if (outRdy) begin
         mValid = 1'b0;
         mReady = 1'b1;
      end
   end

   always @(negedge clk) begin
      checkOutput("in_ready", inRdy, mReady);
      checkOutput("out_valid", outVal, mValid);
      if (mValid) checkOutput("y", yOut, mExp);
   end

   initial begin
      logic [0:SIDE-1] v;
      logic [0:SIDE-1] expV;
      bit   iv;
      int   cyc;
      int   n;
      bit   done;
      bit   hs;
      bit   r;

      rst    = 1'b1;
      inVal  = 1'b0;
      outRdy = 1'b0;
      invIn  = 1'b0;
      xIn    = '0;
      repeat (3) tick();
      rst = 1'b0;
      checkOutput("rst_in_ready", inRdy, 1);
      checkOutput("rst_out_valid", outVal, 0);
      checkOutput("rst_y", yOut, 0);

      // Known vector, forward.
      outRdy = 1'b1;
      applyStimulus(X1, 1'b0);
      waitValid(cyc);
      checkOutput("lat_fwd", cyc, 6);
      checkOutput("y_fwd", yOut, Y1);
      tick();
      checkOutput("idle_after_fwd", inRdy, 1);

      // Feed the result back with inv=1.
      applyStimulus(Y1, 1'b1);
      waitValid(cyc);
      checkOutput("lat_inv", cyc, 6);
      expV = INV_ON ? X1 : refRot(Y1, 1'b0);
      checkOutput("y_inv", yOut, expV);
      tick();

      // Original vector with inv=1.
      applyStimulus(X1, 1'b1);
      waitValid(cyc);
      expV = INV_ON ? refRot(X1, 1'b1) : Y1;
      checkOutput("y_x1_inv", yOut, expV);
      tick();

      // Backpressure with stray in_valid pulses.
      outRdy = 1'b0;
      v  = randVec();
      iv = 1'($urandom);
      applyStimulus(v, iv);
      waitValid(cyc);
      expV = refRot(v, INV_ON && iv);
      for (int i = 0; i < 10; i++) begin
         xIn   = randVec();
         inVal = 1'b1;
         tick();
         checkOutput("bp_y", yOut, expV);
         checkOutput("bp_valid", outVal, 1);
         checkOutput("bp_ready", inRdy, 0);
      end
      inVal  = 1'b0;
      outRdy = 1'b1;
      tick();
      checkOutput("bp_release_ready", inRdy, 1);
      checkOutput("bp_release_valid", outVal, 0);

      // Reset during shift cycle 2, then reset colliding with in_valid.
      applyStimulus(randVec(), 1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("midrst_valid", outVal, 0);
      checkOutput("midrst_ready", inRdy, 1);
      checkOutput("midrst_y", yOut, 0);
      rst   = 1'b1;
      inVal = 1'b1;
      xIn   = randVec();
      tick();
      rst   = 1'b0;
      inVal = 1'b0;
      checkOutput("rst_wins_ready", inRdy, 1);
      checkOutput("rst_wins_y", yOut, 0);
      v = randVec();
      applyStimulus(v, 1'b0);
      waitValid(cyc);
      checkOutput("after_rst_lat", cyc, 6);
      checkOutput("after_rst_y", yOut, refRot(v, 1'b0));
      tick();

      // Random traffic: random backpressure, stray in_valid, occasional reset.
      for (int t = 0; t < 120; t++) begin
         repeat ($urandom_range(0, 2)) tick();
         outRdy = 1'b0;
         applyStimulus(randVec(), 1'($urandom));
         n    = 0;
         done = 1'b0;
         while (!done && n < 200) begin
            outRdy = 1'($urandom);
            inVal  = ($urandom % 4) == 0;
            xIn    = randVec();
            invIn  = 1'($urandom);
            rst    = ($urandom % 60) == 0;
            hs     = outVal && outRdy;
            r      = rst;
            tick();
            rst = 1'b0;
            n++;
            if (hs || r) done = 1'b1;
         end
         inVal  = 1'b0;
         outRdy = 1'b0;
         if (!done) checkOutput("txn_timeout", done, 1);
      end

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
